seq_multiplier: RTL and testbench

Multi-cycle 32x32→64 shift-add multiplier for the MIPS EX stage, implementing MULT/MULTU into the HI/LO pair. It sits directly downstream of the 32-bit ALU adder. Each iteration is a 32-bit add with carry-out on the running partial product, exactly the adder's datapath. The result lands in HI/LO registers read by MFHI/MFLO.

---
 rtl/seq_multiplier.sv | 101 ++++++++++
 tb/tb_seq_multiplier.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Multi-cycle 32x32->64 shift-add multiplier (MULT/MULTU) feeding the HI/LO pair.
// Signed operands are reduced to magnitudes, multiplied unsigned, then negated if needed.
module seq_multiplier (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [63:0] r_p;
    logic [31:0] r_mcand;
    logic        r_neg;
    logic [5:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [63:0] w_p_fix;

    // 0x80000000 negates to itself, which is the right magnitude read as unsigned.
    assign w_a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;
    assign w_sum   = {1'b0, r_p[63:32]} + {1'b0, (r_p[0] ? r_mcand : 32'd0)};
    assign w_p_fix = r_neg ? (~r_p + 64'd1) : r_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_p     <= 64'd0;
            r_mcand <= 32'd0;
            r_neg   <= 1'b0;
            r_count <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_neg   <= is_signed & (a[31] ^ b[31]);
                        r_mcand <= w_a_mag;
                        r_p     <= {32'd0, w_b_mag};
                        r_count <= 6'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // The count is tested before adding, so the hand-off to FIX costs one cycle.
                    if (r_count == 6'd32) begin
                        r_state <= S_FIX;
                    end else begin
                        r_p     <= {w_sum, r_p[31:1]};
                        r_count <= r_count + 6'd1;
                    end
                end
                S_FIX: begin
                    r_p     <= w_p_fix;
                    r_hi    <= w_p_fix[63:32];
                    r_lo    <= w_p_fix[31:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: products, latency, handshake and reset abort.
module tb_seq_multiplier;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    seq_multiplier dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (reset_n && (busy || done))
            check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
    end

    // Returns the number of edges after the accept edge at which done was seen, or -1.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = n;
                return;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        a = ta; b = tb_v; is_signed = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; is_signed = ~ts;
        check({tag, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd34);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        $display("op %s a=%h b=%h signed=%0d -> hi=%h lo=%h latency=%0d", tag, ta, tb_v, ts, hi, lo, cyc);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int cyc;
        int n_done;
        int first_done;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("u_small",   32'd7,         32'd6,         1'b0, 32'h0000_0000, 32'h0000_002A);
        run_op("u_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("s_mixed",   32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("u_mixed",   32'hFFFF_FFFD, 32'd5,         1'b0, 32'h0000_0004, 32'hFFFF_FFF1);
        run_op("s_minmin",  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
        run_op("s_minone",  32'h8000_0000, 32'd1,         1'b1, 32'hFFFF_FFFF, 32'h8000_0000);

        // Second start at E5 must be ignored: one done, first operands' product.
        a = 32'h1234_5678; b = 32'h10; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first_done = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (n == 33) check("hs_busy_E33", {63'd0, busy}, 64'd1);
            if (n == 34) check("hs_busy_E34", {63'd0, busy}, 64'd0);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = n;
            end
        end
        start = 1'b0;
        check("hs_done_count", 64'(n_done), 64'd1);
        check("hs_done_edge", 64'(first_done), 64'd34);
        check("hs_result", {hi, lo}, 64'h0000_0001_2345_6780);
        $display("op handshake dones=%0d first=%0d hi=%h lo=%h", n_done, first_done, hi, lo);

        // start held during the done cycle is refused; accepted one cycle later.
        a = 32'd100; b = 32'd100; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("ra_first_lo", {32'd0, lo}, 64'h2710);
        a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        check("ra_refused_in_done", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("ra_accepted_next", {63'd0, busy}, 64'd1);
        wait_done(cyc);
        check("ra_latency", 64'(cyc), 64'd34);
        check("ra_result", {hi, lo}, 64'd12);
        $display("op reaccept 3x4 hi=%h lo=%h latency=%0d", hi, lo, cyc);
        @(posedge clk); #1;

        // Reset mid-operation aborts and clears HI/LO.
        run_op("pre_abort", 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A);
        a = 32'd3; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        $display("op abort dones_after=%0d hi=%h lo=%h", n_done, hi, lo);
        run_op("post_abort", 32'd2, 32'd2, 1'b0, 32'h0, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
